// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 generator fed by a valid/ready byte handshake.
// Each accepted byte is folded into the CRC register MSB first, one bit per
// clock, through a two-input XOR feedback on every polynomial tap.
// Optional feature macro: CRC8_CHECK_EN adds crc_ok, a zero-residue flag
// that is valid alongside crc_valid.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_first,
  input  logic       in_last,
  output logic       crc_valid,
  output logic [7:0] crc_out,
`ifdef CRC8_CHECK_EN
  output logic       busy,
  output logic       crc_ok
`else
  output logic       busy
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [7:0] crc_reg;
  logic [7:0] data_reg;
  logic [3:0] bit_cnt;
  logic       last_reg;
  logic       fb;
  logic [7:0] crc_next;

  // One LFSR step: feedback is the CRC MSB XORed with the next message bit
  always_comb begin
    fb       = crc_reg[7] ^ data_reg[7];
    crc_next = {crc_reg[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  // Handshake, bit-serial shifting and message framing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_reg  <= INIT;
      data_reg <= 8'h00;
      bit_cnt  <= 4'd0;
      last_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_reg <= in_data;
            last_reg <= in_last;
            bit_cnt  <= 4'd8;
            state    <= SHIFT;
            if (in_first) begin
              crc_reg <= INIT;
            end
          end
        end
        SHIFT: begin
          crc_reg  <= crc_next;
          data_reg <= {data_reg[6:0], 1'b0};
          bit_cnt  <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd1) begin
            state <= last_reg ? DONE : IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign crc_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign crc_out   = crc_reg;

`ifdef CRC8_CHECK_EN
  assign crc_ok = (state == DONE) && (crc_reg == 8'h00);
`endif

endmodule
